// File: rtl/ram_word_ctrl.sv
// Access sequencer for a 4-word x WIDTH latch-based RAM array.
// Each host request runs through SETUP -> STROBE -> HOLD so that the latch
// inputs (rw_mode, data_out) are stable before word_sel rises and after it
// falls. Every output comes straight from a flop.
module ram_word_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic [3:0]       word_sel,
    output logic             rw_mode,
    output logic [WIDTH-1:0] data_out,
    input  logic [WIDTH-1:0] data_in
);

    // A strobe of zero cycles would never open the latch, so 0 is treated as 1.
    localparam int         SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam logic [3:0] CNT_LOAD   = 4'(SETTLE_EFF - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RESP
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic [1:0]       lat_addr;
    logic             latch_req;
    logic             req_ready_nxt;
    logic             rsp_valid_nxt;
    logic [WIDTH-1:0] rsp_rdata_nxt;
    logic [3:0]       word_sel_nxt;
    logic             rw_mode_nxt;
    logic [WIDTH-1:0] data_out_nxt;

    // Next-state and next-output decode; outputs are computed one cycle
    // ahead so they can be registered without a combinational path.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nxt     = state;
        cnt_nxt       = cnt;
        latch_req     = 1'b0;
        req_ready_nxt = 1'b0;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = rsp_rdata;
        word_sel_nxt  = 4'b0000;
        rw_mode_nxt   = rw_mode;
        data_out_nxt  = data_out;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_nxt    = SETUP;
                    latch_req    = 1'b1;
                    rw_mode_nxt  = req_we;
                    data_out_nxt = req_we ? req_wdata : '0;
                end else begin
                    req_ready_nxt = 1'b1;
                end
            end
            SETUP: begin
                state_nxt    = STROBE;
                cnt_nxt      = CNT_LOAD;
                word_sel_nxt = 4'b0001 << lat_addr;
            end
            STROBE: begin
                if (cnt == 4'd0) begin
                    state_nxt = HOLD;
                    if (!rw_mode) begin
                        rsp_rdata_nxt = data_in;
                    end
                end else begin
                    cnt_nxt      = cnt - 4'd1;
                    word_sel_nxt = word_sel;
                end
            end
            HOLD: begin
                // word_sel is already low here, so the bus may now change.
                state_nxt     = RESP;
                rsp_valid_nxt = 1'b1;
                rw_mode_nxt   = 1'b0;
                data_out_nxt  = '0;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt     = IDLE;
                    req_ready_nxt = 1'b1;
                end else begin
                    rsp_valid_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, phase counter, latched address and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_addr  <= 2'd0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            word_sel  <= 4'b0000;
            rw_mode   <= 1'b0;
            data_out  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            req_ready <= req_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            word_sel  <= word_sel_nxt;
            rw_mode   <= rw_mode_nxt;
            data_out  <= data_out_nxt;
            if (latch_req) begin
                lat_addr <= req_addr;
            end
        end
    end

endmodule

// File: tb/tb_ram_word_ctrl.sv
// Self-checking bench for ram_word_ctrl: a latch-array model answers the
// controller, and a word-level reference memory predicts read data.
module tb_ram_word_ctrl;

    localparam int W  = 8;
    localparam int SC = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic         req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [1:0]   req_addr = 2'd0;
    logic [W-1:0] req_wdata = '0;
    logic         req_ready, rsp_valid, rw_mode;
    logic [W-1:0] rsp_rdata, data_out, data_in;
    logic [3:0]   word_sel;

    logic         req_valid0 = 1'b0, req_we0 = 1'b0, rsp_ready0 = 1'b0;
    logic [1:0]   req_addr0 = 2'd0;
    logic [W-1:0] req_wdata0 = '0;
    logic         req_ready0, rsp_valid0, rw_mode0;
    logic [W-1:0] rsp_rdata0, data_out0, data_in0;
    logic [3:0]   word_sel0;

    int           vectors = 0;
    int           miscompares = 0;

    logic [W-1:0] arr [4];
    logic [W-1:0] ref_mem [4];
    logic [W-1:0] last_read = '0;

    always #5 clk = ~clk;

    ram_word_ctrl #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .word_sel(word_sel), .rw_mode(rw_mode), .data_out(data_out),
        .data_in(data_in)
    );

    ram_word_ctrl #(.WIDTH(W), .SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_addr(req_addr0), .req_wdata(req_wdata0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0),
        .word_sel(word_sel0), .rw_mode(rw_mode0), .data_out(data_out0),
        .data_in(data_in0)
    );

    // Latch array: a selected word follows data_out while in write mode.
    always @(negedge clk) begin
        if (rw_mode) begin
            for (int i = 0; i < 4; i++) begin
                if (word_sel[i]) arr[i] <= data_out;
            end
        end
    end

    // Array read port: the selected word, 0 when nothing is selected.
    always_comb begin
        data_in = '0;
        for (int i = 0; i < 4; i++) begin
            if (word_sel[i]) data_in = arr[i];
        end
    end

    assign data_in0 = (word_sel0 != 4'b0000) ? 8'h77 : 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One full access; called at a negedge, returns at the negedge after the
    // response handshake. waits = cycles spent before req_ready was seen.
    task automatic do_txn(input logic we, input logic [1:0] addr, input logic [W-1:0] wdata,
                          input int delay, input bit keep_valid, input bit rand_rdy,
                          output int waits);
        logic [W-1:0] exp_d, exp_r;
        logic [3:0]   onehot;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        waits = 0;
        while (!req_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready) begin
            check("accept_timeout", {31'd0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (!keep_valid) req_valid = 1'b0;
        exp_d  = we ? wdata : '0;
        onehot = 4'b0001 << addr;
        if (we) begin
            ref_mem[addr] = wdata;
            exp_r = last_read;
        end else begin
            exp_r = ref_mem[addr];
            last_read = exp_r;
        end
        // Cycle k after accept: 1 = setup, 2..SC+1 = strobe, SC+2 = hold.
        for (int k = 1; k <= SC + 2; k++) begin
            check("busy_ready", {31'd0, req_ready}, 32'd0);
            check("busy_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            check("busy_rw_mode", {31'd0, rw_mode}, {31'd0, we});
            check("busy_data_out", {24'd0, data_out}, {24'd0, exp_d});
            check("busy_word_sel", {28'd0, word_sel},
                  (k >= 2 && k <= SC + 1) ? {28'd0, onehot} : 32'd0);
            rsp_ready = rand_rdy ? 1'($urandom % 2) : 1'b0;
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        for (int d = 0; d <= delay; d++) begin
            check("resp_valid", {31'd0, rsp_valid}, 32'd1);
            check("resp_rdata", {24'd0, rsp_rdata}, {24'd0, exp_r});
            check("resp_ready", {31'd0, req_ready}, 32'd0);
            check("resp_word_sel", {28'd0, word_sel}, 32'd0);
            check("resp_rw_mode", {31'd0, rw_mode}, 32'd0);
            check("resp_data_out", {24'd0, data_out}, 32'd0);
            if (d < delay) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("done_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waits, edges, sel_cnt;
        logic [3:0] sel_seen;

        // Reset state.
        #12;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_word_sel", {28'd0, word_sel}, 32'd0);
        check("rst_rw_mode", {31'd0, rw_mode}, 32'd0);
        check("rst_data_out", {24'd0, data_out}, 32'd0);
        check("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // Directed writes and read-back.
        do_txn(1'b1, 2'd2, 8'hA5, 0, 1'b0, 1'b0, waits);
        do_txn(1'b1, 2'd0, 8'h11, 0, 1'b0, 1'b0, waits);
        do_txn(1'b1, 2'd3, 8'h33, 1, 1'b0, 1'b0, waits);
        do_txn(1'b1, 2'd1, 8'h3C, 0, 1'b0, 1'b0, waits);
        do_txn(1'b0, 2'd1, 8'h00, 0, 1'b0, 1'b0, waits);

        // Back-to-back with req_valid held high.
        do_txn(1'b1, 2'd0, 8'h5A, 0, 1'b1, 1'b0, waits);
        do_txn(1'b0, 2'd2, 8'h00, 0, 1'b0, 1'b0, waits);
        check("b2b_accept_wait", waits, 32'd0);

        // Response stalled for 5 cycles with a new request pending.
        do_txn(1'b0, 2'd0, 8'h00, 5, 1'b1, 1'b0, waits);
        do_txn(1'b0, 2'd3, 8'h00, 0, 1'b0, 1'b0, waits);
        check("stall_accept_wait", waits, 32'd0);

        // Reset in the middle of a write strobe.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 2'd3; req_wdata = 8'hEE;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_strobe_sel", {28'd0, word_sel}, 32'd8);
        #2 rst_n = 1'b0;
        #1;
        check("abort_sel_async", {28'd0, word_sel}, 32'd0);
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_rdata", {24'd0, rsp_rdata}, 32'd0);
        last_read = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
            check("abort_no_sel", {28'd0, word_sel}, 32'd0);
        end
        do_txn(1'b0, 2'd0, 8'h00, 0, 1'b0, 1'b0, waits);
        do_txn(1'b1, 2'd3, 8'h9D, 0, 1'b0, 1'b0, waits);

        // Randomized accesses, rsp_ready toggling while busy.
        for (int n = 0; n < 40; n++) begin
            do_txn(1'($urandom % 2), 2'($urandom_range(0, 3)), 8'($urandom),
                   int'($urandom_range(0, 3)), 1'b0, 1'b1, waits);
        end

        // Zero settle build: strobe is one cycle, response 3 edges after accept.
        @(negedge clk);
        req_valid0 = 1'b1; req_we0 = 1'b0; req_addr0 = 2'd1;
        check("sc0_ready", {31'd0, req_ready0}, 32'd1);
        @(negedge clk);
        req_valid0 = 1'b0;
        edges = 0; sel_cnt = 0; sel_seen = 4'b0000;
        while (!rsp_valid0 && edges < 20) begin
            if (word_sel0 != 4'b0000) begin
                sel_cnt++;
                sel_seen = word_sel0;
            end
            @(negedge clk);
            edges++;
        end
        check("sc0_latency", edges, 32'd3);
        check("sc0_strobe_len", sel_cnt, 32'd1);
        check("sc0_word_sel", {28'd0, sel_seen}, 32'd2);
        check("sc0_rdata", {24'd0, rsp_rdata0}, 32'h77);
        rsp_ready0 = 1'b1;
        @(negedge clk);
        rsp_ready0 = 1'b0;
        check("sc0_done", {31'd0, rsp_valid0}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
